// File: rtl/rx_interface.sv
// Receive-side parser: pops bytes from a first-word-fall-through FIFO and converts
// terminator-ended ASCII decimal strings into an 8-bit value, flagging malformed input.
module rx_interface #(
   parameter int unsigned    DBIT       = 8,
   parameter int unsigned    MAX_DIGITS = 3,
   parameter logic [DBIT-1:0] TERM      = 8'h0D
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx_empty,
   input  logic [DBIT-1:0] r_data,
   output logic            rd,
   output logic [DBIT-1:0] dout,
   output logic            dout_valid,
   output logic            err
);

   localparam int unsigned AW = 9;
   localparam int unsigned CW = $clog2(MAX_DIGITS + 1);

   typedef enum logic [0:0] {StIdle, StDecode} state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   acc_q, acc_d;
   logic [CW-1:0]   count_q, count_d;
   logic [DBIT-1:0] byte_q, byte_d;
   logic            discard_q, discard_d;
   logic            rd_q, rd_d;
   logic [DBIT-1:0] dout_q, dout_d;
   logic            valid_q, valid_d;
   logic            err_q, err_d;

   logic            is_digit;
   logic            is_term;
   logic [12:0]     next_val;

   assign is_digit = (byte_q >= DBIT'(8'h30)) && (byte_q <= DBIT'(8'h39));
   assign is_term  = (byte_q == TERM);
   // Wide enough for a 255 accumulator times ten plus nine, before the range check.
   assign next_val = 13'(acc_q) * 13'd10 + 13'(byte_q[3:0]);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         acc_q     <= '0;
         count_q   <= '0;
         byte_q    <= '0;
         discard_q <= 1'b0;
         rd_q      <= 1'b0;
         dout_q    <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         count_q   <= count_d;
         byte_q    <= byte_d;
         discard_q <= discard_d;
         rd_q      <= rd_d;
         dout_q    <= dout_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
      end
   end

   // DECODE always returns to IDLE, so rx_empty is never sampled while rd is high.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (!rx_empty) state_d = StDecode;
         StDecode: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      acc_d     = acc_q;
      count_d   = count_q;
      byte_d    = byte_q;
      discard_d = discard_q;
      rd_d      = 1'b0;
      dout_d    = dout_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!rx_empty) begin
               byte_d = r_data;
               rd_d   = 1'b1;
            end
         end
         StDecode: begin
            if (discard_q) begin
               // Resynchronise: everything up to and including the terminator is dropped.
               if (is_term) begin
                  acc_d     = '0;
                  count_d   = '0;
                  discard_d = 1'b0;
               end
            end else if (is_digit) begin
               if (count_q == CW'(MAX_DIGITS) || next_val > 13'd255) begin
                  err_d     = 1'b1;
                  discard_d = 1'b1;
               end else begin
                  acc_d   = next_val[AW-1:0];
                  count_d = count_q + CW'(1);
               end
            end else if (is_term) begin
               if (count_q != '0) begin
                  dout_d  = DBIT'(acc_q[7:0]);
                  valid_d = 1'b1;
                  acc_d   = '0;
                  count_d = '0;
               end
            end else begin
               err_d     = 1'b1;
               discard_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign rd         = rd_q;
   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign err        = err_q;

endmodule

// File: tb/tb_rx_interface.sv
// Directed bench for rx_interface: FWFT FIFO model, table of byte strings with
// hand-computed results, plus latency, reset and empty-FIFO sequences.
module tb_rx_interface;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx_empty;
   logic [7:0] r_data;
   logic       rd;
   logic [7:0] dout;
   logic       dout_valid;
   logic       err;

   always #5 clk = ~clk;

   rx_interface dut (
      .clk        (clk),
      .reset      (reset),
      .rx_empty   (rx_empty),
      .r_data     (r_data),
      .rd         (rd),
      .dout       (dout),
      .dout_valid (dout_valid),
      .err        (err)
   );

   typedef struct {
      logic [63:0] bytes;
      int          n;
      int          exp_dout;
      int          exp_valid;
      int          exp_err;
      int          exp_rd;
   } vec_t;

   vec_t       vecs[12];
   logic [7:0] fifo[$];
   bit         pop_pending = 0;
   bit         hold_empty  = 0;
   int         gap_len = 0;
   int         gap     = 0;
   int         errors  = 0;
   int         checks  = 0;
   int         rd_cnt, valid_cnt, err_cnt;
   int         viol_cnt = 0;
   int         cyc      = 0;
   int         term_cyc, valid_cyc;
   logic [7:0] last_valid;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive();
      rx_empty = hold_empty || (gap > 0) || (fifo.size() == 0);
      r_data   = (fifo.size() > 0) ? fifo[0] : 8'h00;
   endtask

   task automatic clear_counts();
      rd_cnt    = 0;
      valid_cnt = 0;
      err_cnt   = 0;
   endtask

   // One clock: the FIFO head advances only after the edge that ends the rd cycle.
   task automatic tick();
      bit was_empty;
      was_empty = rx_empty;
      @(posedge clk);
      #1;
      cyc++;
      if (pop_pending) begin
         if (fifo.size() > 0) void'(fifo.pop_front());
         pop_pending = 0;
         gap = gap_len;
      end else if (gap > 0) begin
         gap--;
      end
      if (rd) begin
         rd_cnt++;
         if (was_empty || fifo.size() == 0) viol_cnt++;
         pop_pending = 1;
      end
      if (dout_valid) begin
         valid_cnt++;
         last_valid = dout;
         valid_cyc  = cyc;
      end
      if (err) err_cnt++;
      if (dout_valid && err) viol_cnt++;
      drive();
      if (!rx_empty && r_data == 8'h0D && term_cyc < 0) term_cyc = cyc;
   endtask

   task automatic run_until_idle();
      int n;
      n = 0;
      while ((fifo.size() > 0 || pop_pending) && n < 2000) begin
         tick();
         n++;
      end
      if (n >= 2000) begin
         checks++;
         errors++;
         $display("FAIL timeout: fifo still holds %0d bytes after %0d cycles", fifo.size(), n);
      end
      repeat (4) tick();
   endtask

   task automatic push_bytes(input logic [63:0] bytes, input int n);
      for (int i = 0; i < n; i++) fifo.push_back(bytes[63-8*i -: 8]);
   endtask

   initial begin
      vecs[0]  = '{64'h3132_330D_0000_0000, 4, 123, 1, 0, 4}; // "123\r"
      vecs[1]  = '{64'h3235_350D_0000_0000, 4, 255, 1, 0, 4}; // "255\r"
      vecs[2]  = '{64'h3235_360D_0000_0000, 4, 255, 0, 1, 4}; // "256\r"
      vecs[3]  = '{64'h3132_3334_0D37_0D00, 7, 7,   1, 1, 7}; // "1234\r7\r"
      vecs[4]  = '{64'h3030_370D_0000_0000, 4, 7,   1, 0, 4}; // "007\r"
      vecs[5]  = '{64'h3478_350D_0D39_0D00, 7, 9,   1, 1, 7}; // "4x5\r\r9\r"
      vecs[6]  = '{64'h0D00_0000_0000_0000, 1, 9,   0, 0, 1}; // "\r"
      vecs[7]  = '{64'h300D_0000_0000_0000, 2, 0,   1, 0, 2}; // "0\r"
      vecs[8]  = '{64'h2D35_0D00_0000_0000, 3, 0,   0, 1, 3}; // "-5\r"
      vecs[9]  = '{64'h3039_390D_0000_0000, 4, 99,  1, 0, 4}; // "099\r"
      vecs[10] = '{64'h3235_0D00_0000_0000, 3, 25,  1, 0, 3}; // "25\r"
      vecs[11] = '{64'h3030_3030_0D00_0000, 5, 25,  0, 1, 5}; // "0000\r"

      term_cyc = -1;
      valid_cyc = -1;
      last_valid = 8'h00;
      reset = 1'b1;
      drive();
      repeat (3) tick();
      reset = 1'b0;
      check("reset_rd", int'(rd), 0);
      check("reset_dout", int'(dout), 0);
      check("reset_valid", int'(dout_valid), 0);
      check("reset_err", int'(err), 0);

      for (int v = 0; v < 12; v++) begin
         clear_counts();
         push_bytes(vecs[v].bytes, vecs[v].n);
         run_until_idle();
         check($sformatf("v%0d_dout", v), int'(dout), vecs[v].exp_dout);
         check($sformatf("v%0d_valid_cnt", v), valid_cnt, vecs[v].exp_valid);
         check($sformatf("v%0d_err_cnt", v), err_cnt, vecs[v].exp_err);
         check($sformatf("v%0d_rd_cnt", v), rd_cnt, vecs[v].exp_rd);
         if (vecs[v].exp_valid > 0)
            check($sformatf("v%0d_valid_value", v), int'(last_valid), vecs[v].exp_dout);
      end

      // Latency from terminator at FIFO head to the valid pulse.
      clear_counts();
      term_cyc  = -1;
      valid_cyc = -1;
      push_bytes(64'h350D_0000_0000_0000, 2);
      run_until_idle();
      check("lat_dout", int'(dout), 5);
      check("lat_cycles", valid_cyc - term_cyc, 2);

      // Reset mid-number discards the partial value.
      clear_counts();
      push_bytes(64'h3132_0000_0000_0000, 2);
      run_until_idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_reset_rd", int'(rd), 0);
      check("mid_reset_dout", int'(dout), 0);
      check("mid_reset_valid", int'(dout_valid), 0);
      check("mid_reset_err", int'(err), 0);
      clear_counts();
      push_bytes(64'h330D_0000_0000_0000, 2);
      run_until_idle();
      check("post_reset_dout", int'(dout), 3);
      check("post_reset_valid_cnt", valid_cnt, 1);
      check("post_reset_err_cnt", err_cnt, 0);

      // FIFO held empty, then bytes arrive with empty gaps between them.
      clear_counts();
      hold_empty = 1;
      push_bytes(64'h3432_0D00_0000_0000, 3);
      drive();
      repeat (20) tick();
      check("empty_hold_rd_cnt", rd_cnt, 0);
      hold_empty = 0;
      gap_len = 3;
      drive();
      run_until_idle();
      gap_len = 0;
      check("gap_dout", int'(dout), 42);
      check("gap_rd_cnt", rd_cnt, 3);
      check("gap_valid_cnt", valid_cnt, 1);

      check("protocol_violations", viol_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
